// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency processor load/store port on a
// register array, plus a host port for single writes and streaming burst
// reads that only touches the array in cycles where the processor is idle.
module dmem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              Clock,
  input  logic              Reset,
  // Processor port
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Data_Out,
  output logic [DATA_W-1:0] Data_In,
  input  logic              DmemEn,
  input  logic              DmemWrEn,
  // Host command port
  input  logic              Host_Cmd_Valid,
  output logic              Host_Cmd_Ready,
  input  logic              Host_Cmd_Wr,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [ADDR_W-1:0] Host_Len,
  input  logic [DATA_W-1:0] Host_Wr_Data,
  // Host burst read stream
  output logic              Host_Rd_Valid,
  input  logic              Host_Rd_Ready,
  output logic [DATA_W-1:0] Host_Rd_Data,
  output logic              Host_Rd_Last,
  // Processor access counters
  output logic [15:0]       Rd_Count,
  output logic [15:0]       Wr_Count
);

  // One extra bit so a full-array burst (Len==0) can be represented.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    HWRITE,
    BURST
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [15:0]       rd_cnt_q;
  logic [15:0]       wr_cnt_q;

  logic proc_rd_c;
  logic proc_wr_c;
  logic host_wr_c;
  logic fetch_c;

  // Access qualifiers; host accesses only take edges where DmemEn is low.
  assign proc_rd_c = DmemEn & ~DmemWrEn;
  assign proc_wr_c = DmemEn & DmemWrEn;
  assign host_wr_c = (state_q == HWRITE) & ~DmemEn;
  assign fetch_c   = (state_q == BURST) & ~DmemEn & (remaining_q != '0) &
                     (~rd_valid_q | Host_Rd_Ready);

  // Processor load data is combinational so it is sampled on the same edge.
  assign Data_In        = proc_rd_c ? mem_q[Mem_Addr] : '0;
  assign Host_Cmd_Ready = (state_q == IDLE);
  assign Host_Rd_Valid  = rd_valid_q;
  assign Host_Rd_Data   = rd_data_q;
  assign Host_Rd_Last   = rd_last_q;
  assign Rd_Count       = rd_cnt_q;
  assign Wr_Count       = wr_cnt_q;

  // Array storage; processor and host writes are mutually exclusive by DmemEn.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (proc_wr_c) begin
        mem_q[Mem_Addr] <= Data_Out;
      end
      if (host_wr_c) begin
        mem_q[addr_q] <= wr_data_q;
      end
    end
  end

  // Host command FSM with registered burst read stream.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Host_Cmd_Valid) begin
            addr_q      <= Host_Addr;
            wr_data_q   <= Host_Wr_Data;
            remaining_q <= (Host_Len == '0) ? CNT_W'(DEPTH) : CNT_W'(Host_Len);
            state_q     <= Host_Cmd_Wr ? HWRITE : BURST;
          end
        end
        HWRITE: begin
          // The write itself is committed by the array block on this edge.
          if (!DmemEn) begin
            state_q <= IDLE;
          end
        end
        BURST: begin
          if (fetch_c) begin
            rd_data_q   <= mem_q[addr_q];
            rd_valid_q  <= 1'b1;
            rd_last_q   <= (remaining_q == CNT_W'(1));
            addr_q      <= ADDR_W'(addr_q + 1'b1);
            remaining_q <= CNT_W'(remaining_q - 1'b1);
          end else if (rd_valid_q && Host_Rd_Ready) begin
            rd_valid_q <= 1'b0;
            if (rd_last_q) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Saturating processor access counters; host traffic is not counted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (proc_rd_c && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (proc_wr_c && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the cardinal_processor Dmem interface.
- Services the processor's load/store requests from a 256 x 64 register array with zero-latency reads and single-cycle writes.
- Provides a secondary host port, used by the bench and the loader, for single-word writes and streaming burst reads over a valid/ready handshake.
- Host traffic uses only the cycles where the processor port is idle. Per-type processor access counters are included.

Parameters:
ADDR_W, 8, address width; matches processor Mem_Addr.
DATA_W, 64, data word width.
DEPTH, 256, number of words; equals 2**ADDR_W.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Mem_Addr  in  [0:ADDR_W-1]  processor word address.
Data_Out  in  [0:DATA_W-1]  processor store data.
Data_In  out  [0:DATA_W-1]  load data returned to the processor.
DmemEn  in  1  processor access enable.
DmemWrEn  in  1  processor write enable; qualified by DmemEn.
Host_Cmd_Valid  in  1  host command valid.
Host_Cmd_Ready  out  1  host command accepted when high together with Valid.
Host_Cmd_Wr  in  1  1 = single write, 0 = burst read.
Host_Addr  in  [0:ADDR_W-1]  command start address.
Host_Len  in  [0:ADDR_W-1]  burst word count; 0 means 256 words.
Host_Wr_Data  in  [0:DATA_W-1]  write data.
Host_Rd_Valid  out  1  burst read data valid.
Host_Rd_Ready  in  1  host can accept read data.
Host_Rd_Data  out  [0:DATA_W-1]  burst read word.
Host_Rd_Last  out  1  marks the final word of a burst.
Rd_Count  out  [0:15]  processor read count, saturating.
Wr_Count  out  [0:15]  processor write count, saturating.

Behaviour:
- Clocking/reset: single clock Clock; Reset is synchronous, active-high, sampled on the rising edge.
- Reset effects: every array word becomes 0; FSM goes to IDLE; Host_Rd_Valid, Host_Rd_Data, Host_Rd_Last, Rd_Count and Wr_Count become 0.
- Reset mid-operation: reset in any state aborts it. A pending host write is dropped and an in-flight burst is discarded.
- Processor read:
  - When DmemEn=1 and DmemWrEn=0, Data_In = mem[Mem_Addr] combinationally, with zero latency, because the processor samples Data_In on the same edge.
  - In all other cycles Data_In = 0.
- Processor write: when DmemEn=1 and DmemWrEn=1, mem[Mem_Addr] <= Data_Out at the edge. The new value is visible to reads from the next cycle; there is no same-cycle bypass.
- Counters: Rd_Count increments on each processor read cycle and Wr_Count on each processor write cycle. Both saturate at 16'hFFFF. Host accesses are never counted.
- Host port slot: a host array access occurs only at an edge where DmemEn=0. The processor always has priority and is never stalled.
- FSM states: IDLE, HWRITE, BURST.
  - Host_Cmd_Ready = (state==IDLE), combinational; it is 1 in the cycle after reset.
  - IDLE: on Valid&&Ready, latch Addr, Len, Wr_Data and Wr. Go to HWRITE if Wr=1, otherwise BURST; remaining = (Len==0) ? 256 : Len.
  - HWRITE: at the first edge with DmemEn=0, mem[addr] <= wr_data, then go to IDLE. Otherwise wait indefinitely.
  - BURST, fetch: a word is fetched at an edge where DmemEn=0, remaining>0, and (Host_Rd_Valid=0 or Host_Rd_Ready=1).
  - BURST, fetch effects:
    - Host_Rd_Data <= mem[addr] and Host_Rd_Valid <= 1.
    - Host_Rd_Last <= (remaining==1).
    - addr increments modulo 256, so 8'hFF wraps to 8'h00.
    - remaining decrements.
  - BURST, handshake:
    - When Valid&&Ready and no fetch occurs, Host_Rd_Valid <= 0.
    - While Valid=1 and Ready=0, Data and Last are held stable.
  - BURST, exit: when Valid&&Ready&&Last, go to IDLE; Host_Cmd_Ready is 1 the following cycle.
  - BURST throughput: with Ready=1 and DmemEn=0 held, one word per cycle. The first word is valid two edges after command acceptance.
- Collision ordering: a processor write at an edge is not seen by a host fetch at that edge; a fetch cannot coincide with DmemEn=1 in any case. A deferred host write lands after any earlier processor store to the same address (last writer wins).
- DmemWrEn while DmemEn=0 is ignored.

Test Plan:
- Reset; host write addr 8'h10, data 64'h0123456789ABCDEF with DmemEn=0 → Host_Cmd_Ready returns to 1 after two edges. Then processor read Mem_Addr=8'h10 → Data_In=64'h0123456789ABCDEF in the same cycle, and Rd_Count=1 after the edge.
- Processor store addr 8'h05 data all-ones → reading 8'h05 in the next cycle returns all-ones and Wr_Count=1. Reading 8'h06 returns 0. Data_In=0 whenever DmemEn=0.
- Host write addr 8'h20 data 64'hA issued while DmemEn=1 for 3 cycles, with a processor store of 64'hB to 8'h20 in cycle 2 → the host write commits at the first DmemEn=0 edge and mem[8'h20]=64'hA. Wr_Count=1.
- Burst Addr=8'hFE Len=4 (the array was preloaded with value=address), Ready=1, DmemEn=0 → four consecutive valid words 8'hFE, 8'hFF, 8'h00, 8'h01. Last is asserted only on the fourth word, and FSM is back in IDLE the next cycle.
- Same burst with Ready low for 2 cycles on word 2 and a DmemEn=1 read pulse on word 3 → word 2 is held stable, one gap cycle appears, no word is skipped or duplicated, and Rd_Count increments by 1.
- Reset asserted mid-burst with Host_Len=0 (256 words) → the next cycle shows Host_Rd_Valid=0, Host_Cmd_Ready=1, counters 0, and all words read back 0.
